operand_packer: RTL and testbench
=================================

# operand_packer

Parametrised byte-stream to operand assembler for the floating-point multiplier datapath. It collects `NOPS` operands of `OPW` bits each from a serial byte stream, with selectable byte order and valid/ready back-pressure on both sides. It presents the packed operands to the downstream arithmetic core with a single valid strobe, and holds them until that core accepts. It sits between the UART/byte receiver and the multiplier core.

## Interface
Parameters:
- `OPW` — 32 — operand width in bits; multiple of 8, ≥ 8.
- `NOPS` — 2 — operands per frame; ≥ 1.
- `MSB_FIRST` — 1 — 1: the first byte of each operand is its most-significant byte; 0: least-significant first.
- `TIMEOUT_CYCLES` — 1024 — idle-cycle limit for a partial frame; used only with `PACKER_TIMEOUT_EN`; ≥ 2.

Ports (derived constant `BPF = NOPS*OPW/8`, bytes per frame):
- `clk` — in — 1 — single clock; all logic on its rising edge.
- `rst` — in — 1 — reset; synchronous, active-low.
- `data` — in — 8 — input byte.
- `DataValid` — in — 1 — `data` is valid this cycle.
- `in_ready` — out — 1 — block accepts a byte this cycle.
- `out_ready` — in — 1 — downstream accepts the packed frame.
- `ops` — out — `NOPS*OPW` — packed operands; operand k is `ops[k*OPW +: OPW]`, and operand 0 is the first received.
- `DVO` — out — 1 — `ops` is valid.
- `byte_cnt` — out — `$clog2(BPF+1)` — bytes accepted in the current frame.
- `timeout_err` — out — 1 — one-cycle pulse when a partial frame is discarded.

## Operation
- States: COLLECT, HOLD.
- `in_ready` = (state == COLLECT). A byte is accepted when `DataValid && in_ready`.
- Accepted byte n (0-based) goes to operand `n / (OPW/8)`, byte slot `j = n % (OPW/8)`:
  - `MSB_FIRST=1`: bits `[OPW-1-8j -: 8]`.
  - `MSB_FIRST=0`: bits `[8j +: 8]`.
- Bytes are staged in an internal shadow register. `ops` changes only on frame completion; it is never partially updated while visible.
- COLLECT:
  - Each accepted byte increments `byte_cnt`.
  - On acceptance of byte `BPF-1`: shadow plus final byte are copied to `ops`, `DVO` ← 1, `byte_cnt` ← 0, state ← HOLD.
- HOLD:
  - `DVO` stays 1; `ops` is stable; `in_ready` = 0, so bytes offered are not consumed and stay pending at the source.
  - On `DVO && out_ready`: `DVO` ← 0, state ← COLLECT.
- `DataValid` while `in_ready` = 0 is ignored; it is neither an error nor counted.
- Reset (`rst` = 0 at an edge): state ← COLLECT, `DVO` ← 0, `ops` ← 0, shadow ← 0, `byte_cnt` ← 0, `timeout_err` ← 0, timeout counter ← 0.
- Reset mid-frame or in HOLD discards all partial or held data; the next accepted byte is byte 0.

## Timing
- Latency: `DVO` rises on the edge that accepts the last byte, i.e. it is high in the following cycle.
- Minimum frame period: `BPF + 1` cycles (`BPF` byte cycles plus one HOLD cycle with `out_ready` tied 1).
- `out_ready` may be high before `DVO`. The handshake completes on the first edge where both are high.
- `in_ready` returns high the cycle after the output handshake.
- `byte_cnt` is registered and reflects bytes accepted before the current edge.

## Configuration
- Macro: `PACKER_TIMEOUT_EN`.
- Defined:
  - In COLLECT with `byte_cnt` > 0, an idle counter increments on each cycle with no accepted byte. It clears on any accepted byte, on frame completion, and on reset.
  - When the counter reaches `TIMEOUT_CYCLES`: `byte_cnt` ← 0, shadow ← 0, counter ← 0, `timeout_err` pulses for one cycle; state stays COLLECT.
  - A byte accepted on the expiry cycle wins: the counter clears, there is no error, and the byte is counted.
  - No counting in HOLD or when `byte_cnt` == 0.
- Undefined: no counter logic; `timeout_err` is tied 0; a partial frame waits indefinitely.

## Test plan
- Default parameters, `out_ready` = 1, bytes 3F,C0,00,00,40,00,00,00 on consecutive cycles:
  - `DVO` is high exactly one cycle, the cycle after byte 8.
  - `ops[31:0]` = 3FC00000, `ops[63:32]` = 40000000.
  - `in_ready` is high again on the next cycle.
- Same stream with `out_ready` = 0 for 5 cycles after `DVO`, while 4 further bytes are offered:
  - `ops` is stable and `in_ready` = 0 throughout.
  - The pending bytes are not consumed.
  - Collection resumes the cycle after `out_ready` rises.
- `MSB_FIRST` = 0, `OPW` = 16, `NOPS` = 3, bytes 01..06 -> `ops` = 0605_0403_0201 (hex, operand 2 first).
- 3 bytes accepted, then `rst` low for one edge, then a full 8-byte frame:
  - Output equals the 8-byte frame only.
  - `byte_cnt` reads 0 right after reset.
- With `PACKER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16:
  - 2 bytes then 16 idle cycles -> `timeout_err` pulses once and `byte_cnt` = 0.
  - Repeat with a byte arriving on the 16th idle cycle -> no error and `byte_cnt` = 3.
- Gapped `DataValid` (random 50% duty) over 100 frames:
  - Every output frame matches the reference packing.
  - No `DVO` without a complete frame.

Source files
------------

// File: rtl/operand_packer.sv
// operand_packer: assembles NOPS operands of OPW bits from a byte stream and
// presents them to the multiplier core with a valid/ready handshake.
// Bytes are staged in a shadow register so that ops only changes when a
// whole frame is complete.
// Optional feature macro: PACKER_TIMEOUT_EN (discard stale partial frames
// after TIMEOUT_CYCLES idle cycles; without it timeout_err is tied 0).
module operand_packer #(
  parameter int OPW            = 32,
  parameter int NOPS           = 2,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           data,
  input  logic                                 DataValid,
  output logic                                 in_ready,
  input  logic                                 out_ready,
  output logic [NOPS*OPW-1:0]                  ops,
  output logic                                 DVO,
  output logic [$clog2(NOPS*OPW/8+1)-1:0]      byte_cnt,
  output logic                                 timeout_err
);

  localparam int OB  = OPW / 8;
  localparam int BPF = NOPS * OB;
  localparam int CW  = $clog2(BPF + 1);
  localparam int FW  = NOPS * OPW;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   shadow;
  logic [FW-1:0]   next_frame;
  logic            accept;
  logic            last;
  logic            expire;

  // Bit position of the LSB of frame byte n within the packed frame.
  function automatic int byte_lsb(input int n);
    int k;
    int j;
    k = n / OB;
    j = n % OB;
    if (MSB_FIRST != 0)
      return k * OPW + OPW - 8 - 8 * j;
    else
      return k * OPW + 8 * j;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst)
      state_q <= COLLECT;
    else
      state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == COLLECT);
    DVO      = (state_q == HOLD);
    accept   = DataValid && (state_q == COLLECT);
    last     = accept && (byte_cnt == CW'(BPF - 1));
    case (state_q)
      COLLECT: if (last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Shadow frame with the incoming byte merged into its slot.
  always_comb begin
    next_frame = shadow;
    for (int i = 0; i < BPF; i++) begin
      if (byte_cnt == CW'(i))
        next_frame[byte_lsb(i) +: 8] = data;
    end
  end

  // Byte staging, frame publication and byte counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ops      <= '0;
      shadow   <= '0;
      byte_cnt <= '0;
    end else if (last) begin
      ops      <= next_frame;
      shadow   <= next_frame;
      byte_cnt <= '0;
    end else if (accept) begin
      shadow   <= next_frame;
      byte_cnt <= byte_cnt + CW'(1);
    end else if (expire) begin
      shadow   <= '0;
      byte_cnt <= '0;
    end
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q;

  // A partial frame expires on the idle cycle that would reach the limit;
  // a byte accepted on that cycle takes precedence.
  assign expire = !accept && (state_q == COLLECT) && (byte_cnt != '0) &&
                  (idle_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter for partial frames, plus the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (accept || expire)
        idle_q <= '0;
      else if ((state_q == COLLECT) && (byte_cnt != '0))
        idle_q <= idle_q + TW'(1);
    end
  end
`else
  // No timeout: TIMEOUT_CYCLES is a positive count, so this is constant 0.
  assign expire      = (TIMEOUT_CYCLES < 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_packer.sv
// Bench for operand_packer: queue-level reference model checked every cycle
// on the default-parameter instance, plus a 16-bit/3-operand LSB-first
// instance checked against a literal frame.
module tb_operand_packer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, DataValid, in_ready, out_ready, DVO, timeout_err;
  logic [7:0]  data;
  logic [63:0] ops;
  logic [3:0]  byte_cnt;

  logic        rst1, dv1, ir1, or1, dvo1, te1;
  logic [7:0]  d1;
  logic [47:0] ops1;
  logic [2:0]  bc1;

  operand_packer #(.OPW(32), .NOPS(2), .MSB_FIRST(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .data(data), .DataValid(DataValid), .in_ready(in_ready),
    .out_ready(out_ready), .ops(ops), .DVO(DVO), .byte_cnt(byte_cnt),
    .timeout_err(timeout_err));

  operand_packer #(.OPW(16), .NOPS(3), .MSB_FIRST(0), .TIMEOUT_CYCLES(TO)) dut_small (
    .clk(clk), .rst(rst1), .data(d1), .DataValid(dv1), .in_ready(ir1),
    .out_ready(or1), .ops(ops1), .DVO(dvo1), .byte_cnt(bc1),
    .timeout_err(te1));

  int npass = 0;
  int ntot  = 0;
  bit small_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else
      npass++;
  endtask

  // Reference model: list of accepted bytes, held frame, idle count.
  bit          m_hold;
  int          m_n;
  int          m_idle;
  bit          m_terr;
  int          m_frames;
  logic [63:0] m_ops;
  logic [7:0]  m_buf [8];

  function automatic logic [63:0] pack_frame();
    logic [63:0] f;
    int k, j, pos;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      k = i / 4;
      j = i % 4;
      pos = k * 32 + 24 - 8 * j;
      f[pos +: 8] = m_buf[i];
    end
    return f;
  endfunction

  task automatic model_step(input bit rstn, input bit dv, input logic [7:0] d, input bit ordy);
    if (!rstn) begin
      m_hold = 1'b0; m_n = 0; m_idle = 0; m_terr = 1'b0; m_ops = '0;
      return;
    end
    m_terr = 1'b0;
    if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (dv) begin
      m_buf[m_n] = d;
      m_n++;
      m_idle = 0;
      if (m_n == 8) begin
        m_ops = pack_frame();
        m_hold = 1'b1;
        m_n = 0;
        m_frames++;
      end
    end else if (m_n > 0) begin
`ifdef PACKER_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        m_n = 0; m_idle = 0; m_terr = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(!m_hold));
    chk("dvo", 64'(DVO), 64'(m_hold));
    chk("byte_cnt", 64'(byte_cnt), 64'(m_n));
    chk("ops", ops, m_ops);
    chk("timeout_err", 64'(timeout_err), 64'(m_terr));
  endtask

  task automatic tick(input bit rstn, input bit dv, input logic [7:0] d, input bit ordy);
    rst = rstn; DataValid = dv; data = d; out_ready = ordy;
    @(posedge clk);
    model_step(rstn, dv, d, ordy);
    #1;
    check_all();
  endtask

  logic [7:0] fa [8] = '{8'h3F, 8'hC0, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};

  // Main stimulus on the default-parameter instance.
  initial begin
    int start;
    int cyc;
    rst = 1'b0; DataValid = 1'b0; data = '0; out_ready = 1'b0;
    m_frames = 0; m_ops = '0;
    tick(0, 0, 8'h00, 0);
    tick(0, 1, 8'h55, 1);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_ops", ops, 64'd0);

    // Back-to-back frame, out_ready tied high.
    for (int i = 0; i < 8; i++) tick(1, 1, fa[i], 1);
    chk("a_dvo", 64'(DVO), 64'd1);
    chk("a_op0", 64'(ops[31:0]), 64'h3FC00000);
    chk("a_op1", 64'(ops[63:32]), 64'h40000000);
    tick(1, 0, 8'h00, 1);
    chk("a_dvo_one_cycle", 64'(DVO), 64'd0);
    chk("a_ready_again", 64'(in_ready), 64'd1);

    // Same frame held for 5 cycles while further bytes are offered.
    for (int i = 0; i < 8; i++) tick(1, 1, fa[i], 0);
    for (int k = 0; k < 5; k++) begin
      tick(1, 1, 8'hA0 + 8'(k), 0);
      chk("hold_ops", ops, 64'h40000000_3FC00000);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    tick(1, 1, 8'h11, 1);
    chk("release_cnt", 64'(byte_cnt), 64'd0);
    chk("release_ready", 64'(in_ready), 64'd1);
    tick(1, 1, 8'h11, 1);
    chk("resume_cnt", 64'(byte_cnt), 64'd1);
    tick(1, 1, 8'h22, 1);
    tick(1, 1, 8'h33, 1);

    // Reset with 3 bytes pending, then a fresh frame.
    tick(0, 0, 8'h00, 1);
    chk("rst_cnt", 64'(byte_cnt), 64'd0);
    chk("rst_ops", ops, 64'd0);
    for (int i = 0; i < 8; i++) tick(1, 1, 8'(i + 1), 1);
    chk("b_ops", ops, 64'h05060708_01020304);
    tick(1, 0, 8'h00, 1);

`ifdef PACKER_TIMEOUT_EN
    tick(1, 1, 8'h01, 1);
    tick(1, 1, 8'h02, 1);
    for (int k = 0; k < TO - 1; k++) tick(1, 0, 8'h00, 1);
    chk("to_no_early", 64'(timeout_err), 64'd0);
    tick(1, 0, 8'h00, 1);
    chk("to_pulse", 64'(timeout_err), 64'd1);
    chk("to_cnt", 64'(byte_cnt), 64'd0);
    tick(1, 0, 8'h00, 1);
    chk("to_one_cycle", 64'(timeout_err), 64'd0);
    tick(1, 1, 8'h01, 1);
    tick(1, 1, 8'h02, 1);
    for (int k = 0; k < TO - 1; k++) tick(1, 0, 8'h00, 1);
    tick(1, 1, 8'h03, 1);
    chk("to_byte_wins_err", 64'(timeout_err), 64'd0);
    chk("to_byte_wins_cnt", 64'(byte_cnt), 64'd3);
`endif

    // Randomised gapped traffic with random back-pressure.
    start = m_frames;
    cyc = 0;
    while (cyc < 6000 && (m_frames - start) < 100) begin
      tick(1, 1'($urandom % 2), 8'($urandom), 1'(($urandom % 4) != 0));
      cyc++;
    end
    chk("random_frames", 64'(m_frames - start), 64'd100);

    chk("small_done", 64'(small_done), 64'd1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  // LSB-first, 16-bit, 3-operand instance.
  initial begin
    rst1 = 1'b0; dv1 = 1'b0; d1 = '0; or1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      dv1 = 1'b1; d1 = 8'(i);
      @(posedge clk); #1;
    end
    dv1 = 1'b0;
    chk("small_dvo", 64'(dvo1), 64'd1);
    chk("small_ops", 64'(ops1), 64'h0000_0605_0403_0201);
    chk("small_cnt", 64'(bc1), 64'd0);
    chk("small_busy", 64'(ir1), 64'd0);
    @(posedge clk); #1;
    chk("small_dvo_low", 64'(dvo1), 64'd0);
    chk("small_no_err", 64'(te1), 64'd0);
    small_done = 1'b1;
  end

endmodule
